// File: rtl/alu_link_pkg.sv
// Shared widths, LFSR constants and state encoding for the XNOR stream decoder.
package alu_link_pkg;
  localparam int          size     = 16;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [15:0] ZERO_SUB = 16'h0001;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // One right-shift Galois step; the feedback bit is the LSB shifted out.
  function automatic logic [size-1:0] lfsr_step(input logic [size-1:0] k);
    return (k >> 1) ^ (k[0] ? TAPS : '0);
  endfunction
endpackage

// File: rtl/Gate_XNOR.sv
// Generic bitwise XNOR gate shared across the ALU datapath.
module Gate_XNOR #(
  parameter int size = 16
) (
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  output logic [size-1:0] Y
);
  assign Y = ~(A ^ B);
endmodule

// File: rtl/xnor_key_lfsr.sv
// Key register: seed load with zero substitution, LFSR advance on enable.
module xnor_key_lfsr
  import alu_link_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [size-1:0] i_key_in,
  input  logic            i_enable,
  output logic [size-1:0] o_key
);
  logic [size-1:0] r_key;

  // Load wins over advance so a reseed is never perturbed by a same-cycle accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key <= '0;
    end else if (i_load) begin
      r_key <= (i_key_in == '0) ? ZERO_SUB : i_key_in;
    end else if (i_enable) begin
      r_key <= lfsr_step(r_key);
    end
  end

  assign o_key = r_key;
endmodule

// File: rtl/xnor_stream_decoder.sv
// Receive-side XNOR decoder: valid/ready in, one registered output stage out.
module xnor_stream_decoder
  import alu_link_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_key_load,
  input  logic [size-1:0] i_key_in,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [size-1:0] i_in_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [size-1:0] o_out_data,
  output logic            o_keyed,
  output logic [15:0]     o_word_count
);
  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_in_ready;
  logic            w_accept;
  logic [size-1:0] w_key;
  logic [size-1:0] w_dec;
  logic            r_out_valid;
  logic [size-1:0] r_out_data;
  logic [15:0]     r_word_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // in_ready never looks at in_valid, so upstream may gate valid on ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_key_load) w_state_nxt = RUN;
      end
      RUN: begin
        w_in_ready = !r_out_valid || i_out_ready;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = i_in_valid && w_in_ready;

  xnor_key_lfsr u_key (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (i_key_load),
    .i_key_in (i_key_in),
    .i_enable (w_accept && !i_key_load),
    .o_key    (w_key)
  );

  Gate_XNOR #(.size(size)) u_xnor (
    .A (i_in_data),
    .B (w_key),
    .Y (w_dec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_dec;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A word accepted alongside key_load belongs to the old key and is not counted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_word_count <= '0;
    else if (i_key_load) r_word_count <= '0;
    else if (w_accept)   r_word_count <= r_word_count + 16'd1;
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_keyed      = (r_state == RUN);
  assign o_word_count = r_word_count;
endmodule

// File: tb/tb_xnor_stream_decoder.sv
// Scoreboard bench for xnor_stream_decoder: model-driven expectations per cycle.
module tb_xnor_stream_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [15:0] key_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        keyed;
  logic [15:0] word_count;

  int total = 0;
  int bad = 0;

  logic [15:0] m_key = '0;
  logic        m_keyed = 1'b0;
  logic        m_ov = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  xnor_stream_decoder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_load   (key_load),
    .i_key_in     (key_in),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_keyed      (keyed),
    .o_word_count (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_lfsr(input logic [15:0] k);
    logic [15:0] r;
    r = {1'b0, k[15:1]};
    if (k[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_reset();
    m_key = '0; m_keyed = 1'b0; m_ov = 1'b0; m_cnt = '0;
    sb_q.delete();
  endtask

  // Called at a negedge: drive, check combinational/registered outputs, clock, update model.
  task automatic step(input logic kl, input logic [15:0] kin, input logic iv,
                      input logic [15:0] d, input logic ordy);
    logic m_rdy, m_acc;
    key_load = kl; key_in = kin; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    m_rdy = m_keyed && (!m_ov || ordy);
    m_acc = iv && m_rdy;
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("keyed", keyed, m_keyed);
    chk("word_count", word_count, m_cnt);
    chk("key", dut.w_key, m_key);
    if (m_ov) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        chk("out_data", out_data, sb_q[0]);
        if (ordy) void'(sb_q.pop_front());
      end
    end
    if (m_acc) sb_q.push_back(~(d ^ m_key));
    @(posedge clk);
    if (kl) begin
      m_key = (kin == 16'h0) ? 16'h0001 : kin;
      m_keyed = 1'b1;
      m_cnt = '0;
    end else if (m_acc) begin
      m_key = m_lfsr(m_key);
      m_cnt = m_cnt + 16'd1;
    end
    if (m_acc) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_keyed", keyed, 0);
    @(negedge clk);

    // Unkeyed: in_valid ignored.
    step(0, 16'h0, 1, 16'h0147, 1);
    step(0, 16'h0, 1, 16'h0147, 1);

    step(1, 16'h00F8, 0, 16'h0, 1);
    step(0, 16'h0, 1, 16'h0147, 1);
    chk("first_dec", out_data, 16'hFE40);
    chk("first_key", dut.w_key, 16'h007C);
    step(0, 16'h0, 1, 16'hFFFF, 1);
    chk("second_dec", out_data, 16'h007C);

    // Backpressure then drain with same-cycle accept.
    step(0, 16'h0, 1, 16'h1111, 0);
    step(0, 16'h0, 1, 16'h1111, 0);
    step(0, 16'h0, 1, 16'h1111, 0);
    step(0, 16'h0, 1, 16'h2222, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);

    // Zero key substitution.
    step(1, 16'h0000, 0, 16'h0, 1);
    chk("zero_sub_key", dut.w_key, 16'h0001);
    step(0, 16'h0, 1, 16'h0000, 1);
    chk("zero_sub_dec", out_data, 16'hFFFE);
    step(0, 16'h0, 0, 16'h0, 1);
    chk("zero_sub_adv", dut.w_key, 16'hB400);

    // Reload coinciding with an accept: old key decodes, word not counted.
    step(1, 16'h00F8, 0, 16'h0, 1);
    step(1, 16'h1234, 1, 16'h0000, 1);
    chk("kl_acc_dec", out_data, 16'hFF07);
    chk("kl_acc_key", dut.w_key, 16'h1234);
    chk("kl_acc_cnt", word_count, 0);
    step(0, 16'h0, 0, 16'h0, 1);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) == 0), 16'($urandom), $urandom_range(0, 1) == 1,
           16'($urandom), $urandom_range(0, 3) != 0);
    end

    // Mid-stream reset with a pending output held.
    step(0, 16'h0, 1, 16'hABCD, 0);
    step(0, 16'h0, 1, 16'h5555, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_count", word_count, 0);
    chk("mid_rst_keyed", keyed, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 16'h0, 1, 16'h0147, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
